// File: rtl/branch_predictor_pkg.sv
// Shared types for the branch predictor: BTB entry, 2-bit counter, constants.
package branch_predictor_pkg;

    localparam int DATA_WID = 32;

    typedef logic [1:0] ctr2_t;

    // Weakly not-taken after reset.
    localparam ctr2_t CTR_RESET = 2'b01;
    // Weakly taken on fresh BTB allocation.
    localparam ctr2_t CTR_ALLOC = 2'b10;

    // The tag is kept at full data width and holds pc >> (index bits + 2).
    // This lets one struct serve every BTB_ENTRIES setting.
    typedef struct packed {
        logic                valid;
        logic [DATA_WID-1:0] tag;
        logic [DATA_WID-1:0] target;
    } btb_entry_t;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating counter next-value logic.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  ctr2_t cur,
    input  logic  taken,
    output ctr2_t nxt
);

    // Step toward the outcome, holding at 2'b11 and 2'b00.
    always_comb begin
        nxt = cur;
        if (taken) begin
            if (cur != 2'b11) nxt = cur + 2'd1;
        end else begin
            if (cur != 2'b00) nxt = cur - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB plus a 2-bit PHT branch predictor with misprediction redirect.
// Optional macro BPU_GSHARE_EN: index the PHT with the PC index XOR the global history.
// Without the macro, no GHR exists and pred_ghr reads 0.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int BTB_ENTRIES = 16,
    parameter int PHT_ENTRIES = 16,
    parameter int GHR_WID     = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_WID-1:0] pc,
    output logic                pred_taken,
    output logic [DATA_WID-1:0] pred_pc,
    output logic [GHR_WID-1:0]  pred_ghr,
    input  logic                upd_valid,
    input  logic [DATA_WID-1:0] upd_pc,
    input  logic [DATA_WID-1:0] upd_target,
    input  logic                upd_taken,
    input  logic [DATA_WID-1:0] upd_pred_pc,
    input  logic [GHR_WID-1:0]  upd_ghr,
    output logic                redirect,
    output logic [DATA_WID-1:0] redirect_pc,
    output logic [31:0]         mispred_cnt
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    typedef logic [IDX_W-1:0] idx_t;

    function automatic idx_t idx_of(input logic [DATA_WID-1:0] a);
        return a[IDX_W+1:2];
    endfunction

    function automatic logic [DATA_WID-1:0] tag_of(input logic [DATA_WID-1:0] a);
        return a >> (IDX_W + 2);
    endfunction

    btb_entry_t          btb_q [BTB_ENTRIES];
    btb_entry_t          btb_d [BTB_ENTRIES];
    ctr2_t               pht_q [PHT_ENTRIES];
    ctr2_t               pht_d [PHT_ENTRIES];
    logic [31:0]         cnt_q, cnt_d;

    idx_t                lk_idx, lk_pidx, up_idx, up_pidx;
    logic                lk_hit, up_hit;
    logic [DATA_WID-1:0] actual_next;
    ctr2_t               ctr_nxt;

    assign lk_idx = idx_of(pc);
    assign up_idx = idx_of(upd_pc);

`ifdef BPU_GSHARE_EN
    logic [GHR_WID-1:0] ghr_q, ghr_d;
    assign lk_pidx  = lk_idx ^ idx_t'(ghr_q);
    assign up_pidx  = up_idx ^ idx_t'(upd_ghr);
    assign pred_ghr = ghr_q;
`else
    logic unused_upd_ghr;
    assign unused_upd_ghr = ^upd_ghr;
    assign lk_pidx  = lk_idx;
    assign up_pidx  = up_idx;
    assign pred_ghr = '0;
`endif

    // Zero-latency lookup; reads registered state only, so a same-cycle update is not visible.
    assign lk_hit     = btb_q[lk_idx].valid && (btb_q[lk_idx].tag == tag_of(pc));
    assign pred_taken = lk_hit && pht_q[lk_pidx][1];
    assign pred_pc    = pred_taken ? btb_q[lk_idx].target : pc + 32'd4;

    // Resolution compare against what the front end actually fetched next.
    assign actual_next = upd_taken ? upd_target : upd_pc + 32'd4;
    assign redirect    = upd_valid && (actual_next != upd_pred_pc);
    assign redirect_pc = actual_next;
    assign mispred_cnt = cnt_q;

    assign up_hit = btb_q[up_idx].valid && (btb_q[up_idx].tag == tag_of(upd_pc));

    sat_counter2 u_sat (
        .cur   (pht_q[up_pidx]),
        .taken (upd_taken),
        .nxt   (ctr_nxt)
    );

    // Next-state for tables, history and the misprediction counter.
    always_comb begin
        btb_d = btb_q;
        pht_d = pht_q;
        cnt_d = cnt_q;
`ifdef BPU_GSHARE_EN
        ghr_d = ghr_q;
`endif
        if (upd_valid) begin
            pht_d[up_pidx] = ctr_nxt;
            if (upd_taken) begin
                if (up_hit) begin
                    btb_d[up_idx].target = upd_target;
                end else begin
                    btb_d[up_idx] = '{valid: 1'b1, tag: tag_of(upd_pc), target: upd_target};
                    pht_d[up_pidx] = CTR_ALLOC;
                end
            end
`ifdef BPU_GSHARE_EN
            ghr_d = {ghr_q[GHR_WID-2:0], upd_taken};
`endif
        end
        if (redirect && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
    end

    // State registers; reset drops valid bits and any in-flight update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) btb_q[i].valid <= 1'b0;
            for (int i = 0; i < PHT_ENTRIES; i++) pht_q[i] <= CTR_RESET;
            cnt_q <= '0;
`ifdef BPU_GSHARE_EN
            ghr_q <= '0;
`endif
        end else begin
            btb_q <= btb_d;
            pht_q <= pht_d;
            cnt_q <= cnt_d;
`ifdef BPU_GSHARE_EN
            ghr_q <= ghr_d;
`endif
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: per-cycle behavioural model plus directed literals.
module tb_branch_predictor;

    localparam int N  = 16;
    localparam int LG = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic [LG-1:0] pred_ghr;
    logic        upd_valid;
    logic [31:0] upd_pc, upd_target, upd_pred_pc;
    logic        upd_taken;
    logic [LG-1:0] upd_ghr;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] mispred_cnt;

    always #5 clk = ~clk;

    branch_predictor #(.BTB_ENTRIES(N), .PHT_ENTRIES(N), .GHR_WID(LG)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .pred_taken  (pred_taken),
        .pred_pc     (pred_pc),
        .pred_ghr    (pred_ghr),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_target  (upd_target),
        .upd_taken   (upd_taken),
        .upd_pred_pc (upd_pred_pc),
        .upd_ghr     (upd_ghr),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mispred_cnt (mispred_cnt)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Hand-computed expectations assume plain PC indexing.
    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
`ifndef BPU_GSHARE_EN
        chk(name, act, exp);
`endif
    endtask

    // ---------------- behavioural model ----------------
    bit              m_init = 1'b0;
    bit              m_valid [N];
    logic [31:0]     m_tag   [N];
    logic [31:0]     m_tgt   [N];
    int              m_ctr   [N];
    int              m_ghr;
    longint unsigned m_cnt;

    function automatic int bidx(input logic [31:0] a);
        return int'((a >> 2) % N);
    endfunction

    function automatic int pidx(input logic [31:0] a, input int g);
`ifdef BPU_GSHARE_EN
        return bidx(a) ^ g;
`else
        return bidx(a) + 0 * g;
`endif
    endfunction

    // Compare every cycle at negedge, then advance the model with what the DUT will sample at posedge.
    always @(negedge clk) begin : mdl
        int          bi, pi;
        bit          e_hit, e_tk, e_red;
        logic [31:0] e_pc, e_act, e_ghr;
        e_red = 1'b0;
        if (m_init) begin
            bi    = bidx(pc);
            pi    = pidx(pc, m_ghr);
            e_hit = m_valid[bi] && (m_tag[bi] == (pc >> (2 + LG)));
            e_tk  = e_hit && (m_ctr[pi] >= 2);
            e_pc  = e_tk ? m_tgt[bi] : pc + 32'd4;
            e_act = upd_taken ? upd_target : upd_pc + 32'd4;
            e_red = upd_valid && (e_act != upd_pred_pc);
`ifdef BPU_GSHARE_EN
            e_ghr = 32'(m_ghr);
`else
            e_ghr = 32'd0;
`endif
            chk("model pred_taken", {31'd0, pred_taken}, {31'd0, e_tk});
            chk("model pred_pc", pred_pc, e_pc);
            chk("model pred_ghr", {28'd0, pred_ghr}, e_ghr);
            chk("model redirect", {31'd0, redirect}, {31'd0, e_red});
            if (upd_valid) chk("model redirect_pc", redirect_pc, e_act);
            chk("model mispred_cnt", mispred_cnt, m_cnt[31:0]);
        end
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_valid[i] = 1'b0;
                m_ctr[i]   = 1;
            end
            m_ghr  = 0;
            m_cnt  = 0;
            m_init = 1'b1;
        end else if (m_init && upd_valid) begin
            bi    = bidx(upd_pc);
            pi    = pidx(upd_pc, int'(upd_ghr));
            e_hit = m_valid[bi] && (m_tag[bi] == (upd_pc >> (2 + LG)));
            m_ctr[pi] = upd_taken ? ((m_ctr[pi] < 3) ? m_ctr[pi] + 1 : 3)
                                  : ((m_ctr[pi] > 0) ? m_ctr[pi] - 1 : 0);
            if (upd_taken) begin
                m_tgt[bi] = upd_target;
                if (!e_hit) begin
                    m_valid[bi] = 1'b1;
                    m_tag[bi]   = upd_pc >> (2 + LG);
                    m_ctr[pi]   = 2;
                end
            end
            m_ghr = ((m_ghr << 1) | int'(upd_taken)) & (N - 1);
            if (e_red && m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input bit r, input bit uv, input logic [31:0] p, input logic [31:0] up,
                         input bit ut, input logic [31:0] utg, input logic [31:0] upp);
        rst         = r;
        upd_valid   = uv;
        pc          = p;
        upd_pc      = up;
        upd_taken   = ut;
        upd_target  = utg;
        upd_pred_pc = upp;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] nt_upp  [4] = '{32'h200, 32'h104, 32'h104, 32'h200};
    logic [31:0] nt_pred [4] = '{32'h200, 32'h104, 32'h104, 32'h104};
    logic [31:0] nt_red  [4] = '{32'd1, 32'd0, 32'd0, 32'd1};
    logic [31:0] nt_cnt  [4] = '{32'd1, 32'd2, 32'd2, 32'd2};

    initial begin
        upd_ghr = '0;
        drive(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0, 32'h0);
        nxt();
        nxt();

        // Out of reset: fall-through prediction.
        drive(1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0, 32'h0);
        #2;
        lit("reset pred_taken", {31'd0, pred_taken}, 32'd0);
        lit("reset pred_pc", pred_pc, 32'h104);
        lit("reset mispred_cnt", mispred_cnt, 32'd0);
        lit("reset pred_ghr", {28'd0, pred_ghr}, 32'd0);
        nxt();

        // First taken update with a same-cycle lookup (history port driven but ignored without gshare).
        upd_ghr = 4'hA;
        drive(1'b0, 1'b1, 32'h100, 32'h100, 1'b1, 32'h200, 32'h104);
        #2;
        lit("same-cycle pred_pc", pred_pc, 32'h104);
        lit("first redirect", {31'd0, redirect}, 32'd1);
        lit("first redirect_pc", redirect_pc, 32'h200);
        nxt();
        upd_ghr = 4'h0;

        drive(1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0, 32'h0);
        #2;
        lit("after alloc pred_taken", {31'd0, pred_taken}, 32'd1);
        lit("after alloc pred_pc", pred_pc, 32'h200);
        lit("after alloc mispred_cnt", mispred_cnt, 32'd1);
        nxt();

        // Four not-taken resolutions walk the counter 10->01->00->00.
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b1, 32'h100, 32'h100, 1'b0, 32'h200, nt_upp[k]);
            #2;
            lit($sformatf("nt%0d pred_pc", k), pred_pc, nt_pred[k]);
            lit($sformatf("nt%0d redirect", k), {31'd0, redirect}, nt_red[k]);
            lit($sformatf("nt%0d mispred_cnt", k), mispred_cnt, nt_cnt[k]);
            nxt();
        end
        drive(1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0, 32'h0);
        #2;
        lit("after nt pred_pc", pred_pc, 32'h104);
        lit("after nt mispred_cnt", mispred_cnt, 32'd3);
        nxt();

        // Taken hits retarget the entry; counter climbs 00->01->10.
        drive(1'b0, 1'b1, 32'h100, 32'h100, 1'b1, 32'h300, 32'h104);
        #2;
        lit("retarget redirect", {31'd0, redirect}, 32'd1);
        nxt();
        drive(1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0, 32'h0);
        #2;
        lit("weak nt pred_pc", pred_pc, 32'h104);
        nxt();
        drive(1'b0, 1'b1, 32'h100, 32'h100, 1'b1, 32'h300, 32'h104);
        nxt();
        drive(1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0, 32'h0);
        #2;
        lit("retarget pred_pc", pred_pc, 32'h300);
        lit("retarget mispred_cnt", mispred_cnt, 32'd5);
        nxt();

        // Same index, different tag: no hit.
        drive(1'b0, 1'b0, 32'h140, 32'h0, 1'b0, 32'h0, 32'h0);
        #2;
        lit("alias pred_taken", {31'd0, pred_taken}, 32'd0);
        lit("alias pred_pc", pred_pc, 32'h144);
        nxt();

        // Top-of-address wrap on both fall-through paths; not-taken miss leaves BTB alone.
        drive(1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0);
        #2;
        lit("wrap pred_pc", pred_pc, 32'h0);
        lit("wrap redirect", {31'd0, redirect}, 32'd0);
        nxt();
        drive(1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0, 32'h0, 32'h0);
        #2;
        lit("wrap miss pred_taken", {31'd0, pred_taken}, 32'd0);
        nxt();

        // Reset together with an update: reset wins.
        drive(1'b1, 1'b1, 32'h100, 32'h100, 1'b1, 32'h400, 32'h104);
        nxt();
        drive(1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0, 32'h0);
        #2;
        lit("post-rst pred_taken", {31'd0, pred_taken}, 32'd0);
        lit("post-rst pred_pc", pred_pc, 32'h104);
        lit("post-rst mispred_cnt", mispred_cnt, 32'd0);
        nxt();
        drive(1'b0, 1'b0, 32'h140, 32'h0, 1'b0, 32'h0, 32'h0);
        nxt();
        nxt();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
